// File: rtl/seg_capture.sv
// Multiplexed 7-segment display snooper: qualifies stable seg/an pairs, latches the selected
// digit images, decodes them to hex and counts complete four-digit frames.
module seg_capture #(
    parameter int unsigned STABLE_CNT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [31:0] digits,
    output logic [15:0] hex_val,
    output logic [3:0]  hex_ok,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam logic [3:0] CntMax  = 4'(STABLE_CNT);
    localparam logic [3:0] CntQual = 4'(STABLE_CNT - 1);

    typedef enum logic [1:0] {StTrack, StCommit, StHold} state_e;

    state_e      state_q, state_d;
    logic [11:0] smp_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  ok_q, ok_d;
    logic [3:0]  seen_q, seen_d;
    logic        done_q, done_d;
    logic [7:0]  fcnt_q, fcnt_d;

    logic [11:0] smp_in;
    logic        same;
    logic [3:0]  wr_mask;
    logic [3:0]  seen_or;
    logic [7:0]  img;
    logic [4:0]  dec;

    // Returns {legal, nibble} for a {a..g} pattern, a as MSB.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h7E:   decode = 5'h10;
            7'h30:   decode = 5'h11;
            7'h6D:   decode = 5'h12;
            7'h79:   decode = 5'h13;
            7'h33:   decode = 5'h14;
            7'h5B:   decode = 5'h15;
            7'h5F:   decode = 5'h16;
            7'h70:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h7B:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h1F:   decode = 5'h1B;
            7'h4E:   decode = 5'h1C;
            7'h3D:   decode = 5'h1D;
            7'h4F:   decode = 5'h1E;
            7'h47:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        smp_in  = {seg, an};
        same    = (smp_in == smp_q);
        cnt_d   = 4'd1;
        if (same) begin
            cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + 4'd1;
        end

        state_d = state_q;
        wr_mask = 4'b0000;
        unique case (state_q)
            StTrack: begin
                if (same && (cnt_q == CntQual)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                // The registered pair is already qualified, so it is written on this edge.
                wr_mask = ~smp_q[3:0];
                state_d = same ? StHold : StTrack;
            end
            StHold: begin
                if (!same) begin
                    state_d = StTrack;
                end
            end
            default: state_d = StTrack;
        endcase

        img      = ~smp_q[11:4];
        dec      = decode(img[7:1]);
        digits_d = digits_q;
        hex_d    = hex_q;
        ok_d     = ok_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
                digits_d[8*i +: 8] = img;
                hex_d[4*i +: 4]    = dec[3:0];
                ok_d[i]            = dec[4];
            end
        end

        seen_or = seen_q | wr_mask;
        seen_d  = seen_or;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        if ((wr_mask != 4'b0000) && (seen_or == 4'hF)) begin
            seen_d = 4'h0;
            fcnt_d = fcnt_q + 8'd1;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StTrack;
            smp_q    <= {8'hFF, 4'hF};
            cnt_q    <= 4'd0;
            digits_q <= '0;
            hex_q    <= '0;
            ok_q     <= '0;
            seen_q   <= '0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_in;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            hex_q    <= hex_d;
            ok_q     <= ok_d;
            seen_q   <= seen_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign digits     = digits_q;
    assign hex_val    = hex_q;
    assign hex_ok     = ok_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter: STABLE_CNT, default 2, number of consecutive equal samples that qualify a seg/an pair (legal range 2..15).
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 seg  input  8  segment lines, active-low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-005 an  input  4  digit enables, active-low; an[i]=0 selects digit i.
REQ-006 digits  output  32  captured image, active-high (~seg); digit i in bits [8i+7:8i].
REQ-007 hex_val  output  16  decoded hex nibble; digit i in bits [4i+3:4i].
REQ-008 hex_ok  output  4  hex_ok[i]=1 when digit i holds a legal hex glyph.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been written since the last frame.
REQ-010 frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-011 Sample register r={seg,an} shall load every edge; run counter cnt (4 bits) shall load 1 when input != r, else increment, saturating at STABLE_CNT.
REQ-012 FSM states: TRACK, COMMIT, HOLD.
REQ-013 TRACK: input == r and cnt == STABLE_CNT-1 -> COMMIT; otherwise stay in TRACK.
REQ-014 COMMIT (exactly one cycle): on the leaving edge, write the stable r to digits/hex_val/hex_ok of every digit with an low; next state HOLD, or TRACK if input != r.
REQ-015 HOLD: input != r -> TRACK (cnt=1); otherwise stay; a held pair commits only once.
REQ-016 Latency: seg/an constant across edges e1..eN shall update outputs on edge e(STABLE_CNT+1); STABLE_CNT=2 -> 3 edges.
REQ-017 Any change before the commit edge shall discard the pending pair with no output change.
REQ-018 Multiple an bits low: all selected digits written identically on the same edge.
REQ-019 an=4'b1111 at commit: no digit write, no seen change; FSM still goes to HOLD.
REQ-020 Decode {a..g} of the digit image (dp ignored), a as MSB: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
REQ-021 Non-matching image: hex_ok[i]=0, hex_val nibble i=0, digits still updated.
REQ-022 seen[3:0] shall set bits of digits written at each commit.
REQ-023 A commit whose write makes seen==4'hF shall, on that edge, clear seen to 0 and increment frame_cnt; frame_done=1 for the following cycle only.
REQ-024 A commit covering several unseen digits completing the set counts as one frame.
REQ-025 Commit to already-seen digits shall overwrite the data without a frame event.

Reset
REQ-026 RST=1 at an edge: digits=0, hex_val=0, hex_ok=0, frame_done=0, frame_cnt=0, seen=0, r={8'hFF,4'hF}, cnt=0, state TRACK.
REQ-027 RST overrides everything, including a COMMIT in progress; no write occurs on a reset edge.
REQ-028 First qualified pair after RST deasserts shall follow REQ-016 timing from its first sample.

Verification
REQ-029 RST high 2 cycles with random seg/an -> all outputs 0, frame_done never 1.
REQ-030 seg=8'h03, an=4'b1110 held 3 edges -> digits[7:0]=8'hFC, hex_val[3:0]=0, hex_ok[0]=1, other digits 0, no frame_done.
REQ-031 seg=8'h03 an=4'b1110 for 1 edge, then seg=8'hFF an=4'b1111 held -> digits stay 0, hex_ok=0.
REQ-032 seg=8'h7F an=4'b1010 held 3 edges, then seg=8'h7F an=4'b0101 held 3 edges -> all digits 8'h80, hex_ok=0, frame_done 1 for exactly one cycle, frame_cnt=1.
REQ-033 Same pair held 20 edges -> exactly one commit; then an=4'b1111 held -> digits and seen unchanged.
REQ-034 RST asserted on the edge that would commit -> no write; outputs all 0 next cycle.
